// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the one-hot ring slot monitor.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int RING_W    = 8;
    localparam int ERR_CNT_W = 8;
    localparam int ROT_MAX_W = 64;

    // Left rotate by one over the low w bits of v (w <= ROT_MAX_W).
    function automatic logic [ROT_MAX_W-1:0] rot(input logic [ROT_MAX_W-1:0] v, input int w);
        logic [ROT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROT_MAX_W - 1; i++) begin
            if (i < w - 1) r[i+1] = v[i];
        end
        r[0] = v[w-1];
        return r;
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot check and binary encoder for a ring state vector.
module ring_onehot_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         vec,
    output logic                     is_onehot,
    output logic [$clog2(WIDTH)-1:0] idx
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [IDX_W-1:0] term [WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_term
            assign term[gi] = vec[gi] ? IDX_W'(gi) : '0;
        end
    endgenerate

    // OR of per-bit indices is exact only when the input is one-hot.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) idx = idx | term[i];
    end

    assign is_onehot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/ring_slot_monitor.sv
// Monitors a rotating one-hot ring counter: lock, revolution count, sticky errors.
// Optional ring_vld starvation timeout enabled by RING_SLOT_MONITOR_TIMEOUT_EN.
module ring_slot_monitor
    import ring_mon_pkg::*;
#(
    parameter int WIDTH      = RING_W,
    parameter int LOCK_STEPS = 4,
    parameter int ERR_THRESH = 3,
    parameter int REV_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     ring_vld,
    input  logic                     ring_init,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] slot_idx,
    output logic                     slot_vld,
    output logic                     rev_pulse,
    output logic [REV_W-1:0]         rev_cnt,
    output logic                     locked,
    output logic                     fault,
    output logic                     err_onehot,
    output logic                     err_seq,
    output logic [ERR_CNT_W-1:0]     err_cnt
);
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_STEPS + 1);
    localparam int MISS_W = $clog2(ERR_THRESH + 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   prev_reg;
    logic [GOOD_W-1:0]  good_reg;
    logic [MISS_W-1:0]  miss_reg;

    logic               enc_onehot;
    logic [IDX_W-1:0]   enc_idx;
    logic [WIDTH-1:0]   exp_w;
    logic               take, hit, clr_eff, set_oh, set_seq, to_fire;
    logic               err_onehot_next, err_seq_next;
    logic [ERR_CNT_W-1:0] err_base, err_cnt_next;

    ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
        .vec       (ring_in),
        .is_onehot (enc_onehot),
        .idx       (enc_idx)
    );

`ifdef RING_SLOT_MONITOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;

    assign to_fire = (state_reg == LOCKED) && !ring_vld && !ring_init
                     && (to_cnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            to_cnt_reg <= '0;
        else if (state_reg != LOCKED || ring_vld || ring_init || to_fire)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_reg + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_fire        = 1'b0;
`endif

    // Error set dominates clear; ring_init holds the sticky errors untouched.
    always_comb begin
        exp_w           = WIDTH'(rot(ROT_MAX_W'(prev_reg), WIDTH));
        take            = ring_vld && !ring_init;
        hit             = (ring_in == exp_w);
        clr_eff         = clr_err && !ring_init;
        set_oh          = take && !enc_onehot && (state_reg != FAULT);
        set_seq         = take && enc_onehot && !hit
                          && (state_reg == SYNC || state_reg == LOCKED);
        err_base        = clr_eff ? '0 : err_cnt;
        err_onehot_next = (err_onehot && !clr_eff) || set_oh;
        err_seq_next    = (err_seq && !clr_eff) || set_seq || to_fire;
        err_cnt_next    = err_base;
        if ((set_oh || set_seq) && err_base != '1) err_cnt_next = err_base + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            prev_reg   <= '0;
            good_reg   <= '0;
            miss_reg   <= '0;
            slot_idx   <= '0;
            slot_vld   <= 1'b0;
            rev_pulse  <= 1'b0;
            rev_cnt    <= '0;
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            rev_pulse  <= 1'b0;
            err_onehot <= err_onehot_next;
            err_seq    <= err_seq_next;
            err_cnt    <= err_cnt_next;
            if (take) begin
                slot_vld <= enc_onehot;
                if (enc_onehot) slot_idx <= enc_idx;
            end
            if (ring_init) begin
                state_reg <= IDLE;
                good_reg  <= '0;
                miss_reg  <= '0;
                rev_cnt   <= '0;
            end else begin
                case (state_reg)
                    IDLE: if (take && enc_onehot) begin
                        prev_reg  <= ring_in;
                        good_reg  <= '0;
                        state_reg <= SYNC;
                    end
                    SYNC: if (take) begin
                        if (hit) begin
                            prev_reg <= ring_in;
                            good_reg <= good_reg + 1'b1;
                            if (good_reg + 1'b1 == GOOD_W'(LOCK_STEPS)) begin
                                state_reg <= LOCKED;
                                miss_reg  <= '0;
                            end
                        end else if (enc_onehot) begin
                            prev_reg <= ring_in;
                            good_reg <= '0;
                        end else begin
                            good_reg  <= '0;
                            state_reg <= IDLE;
                        end
                    end
                    // Flywheel: prev always advances to the expected value.
                    LOCKED: if (take) begin
                        prev_reg <= exp_w;
                        if (hit) begin
                            miss_reg <= '0;
                            if (ring_in[WIDTH-1]) begin
                                rev_pulse <= 1'b1;
                                rev_cnt   <= rev_cnt + 1'b1;
                            end
                        end else begin
                            miss_reg <= miss_reg + 1'b1;
                            if (miss_reg + 1'b1 == MISS_W'(ERR_THRESH)) state_reg <= FAULT;
                        end
                    end else if (to_fire) begin
                        state_reg <= FAULT;
                    end
                    FAULT: if (clr_eff) begin
                        state_reg <= IDLE;
                        good_reg  <= '0;
                        miss_reg  <= '0;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign locked = (state_reg == LOCKED);
    assign fault  = (state_reg == FAULT);

endmodule

// File: tb/tb_ring_slot_monitor.sv
// Scoreboard bench for ring_slot_monitor: expectations queued at drive time, popped after the edge.
module tb_ring_slot_monitor;

    logic        clk = 1'b0;
    logic        rst_n, ring_vld, ring_init, clr_err;
    logic [7:0]  ring_in;
    logic [2:0]  slot_idx;
    logic        slot_vld, rev_pulse, locked, fault, err_onehot, err_seq;
    logic [15:0] rev_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ring_slot_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ring_in    (ring_in),
        .ring_vld   (ring_vld),
        .ring_init  (ring_init),
        .clr_err    (clr_err),
        .slot_idx   (slot_idx),
        .slot_vld   (slot_vld),
        .rev_pulse  (rev_pulse),
        .rev_cnt    (rev_cnt),
        .locked     (locked),
        .fault      (fault),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic [2:0]  idx;
        logic        vld;
        logic        lk;
        logic        ft;
        logic        eoh;
        logic        eseq;
        logic [7:0]  ecnt;
        logic [15:0] rcnt;
        logic        rp;
    } obs_t;

    typedef struct packed {
        logic [7:0] s;
        logic       v;
        logic       init;
        logic       clr;
        obs_t       e;
    } step_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    function automatic obs_t mk(input logic [2:0] idx, input logic vld, input logic lk,
                                input logic ft, input logic eoh, input logic eseq,
                                input logic [7:0] ecnt, input logic [15:0] rcnt, input logic rp);
        obs_t o;
        o = '{idx: idx, vld: vld, lk: lk, ft: ft, eoh: eoh, eseq: eseq,
              ecnt: ecnt, rcnt: rcnt, rp: rp};
        return o;
    endfunction

    function automatic step_t st(input logic [7:0] s, input logic v, input logic init,
                                 input logic clr, input obs_t e);
        step_t t;
        t = '{s: s, v: v, init: init, clr: clr, e: e};
        return t;
    endfunction

    function automatic obs_t observe();
        return mk(slot_idx, slot_vld, locked, fault, err_onehot, err_seq, err_cnt, rev_cnt, rev_pulse);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("idx=%0d vld=%b lk=%b ft=%b eoh=%b eseq=%b ecnt=%0d rcnt=%0d rp=%b",
                         o.idx, o.vld, o.lk, o.ft, o.eoh, o.eseq, o.ecnt, o.rcnt, o.rp);
    endfunction

    task automatic drive(input logic [7:0] s, input logic v, input logic init,
                         input logic clr, input obs_t e);
        @(negedge clk);
        ring_in   = s;
        ring_vld  = v;
        ring_init = init;
        clr_err   = clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ring_vld  = 1'b0;
        ring_init = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, want;
        rst_n = 1'b0; ring_in = 8'hFF; ring_vld = 1'b1; ring_init = 1'b0; clr_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk);
            #1;
            got = observe();
            checks++;
            want = exp_q.pop_front();
            if (got !== want) $display("FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
            else begin passes++; $display("ok   reset[%0d] %s", i, fmt(got)); end
        end
        @(negedge clk);
        rst_n = 1'b1; ring_vld = 1'b0; ring_in = 8'h00;
    endtask

    // Runs a table: each row drives one cycle, then the queued expectation is popped and compared.
    task automatic run_tab(input string name, input step_t tab[$]);
        obs_t got, want;
        foreach (tab[i]) begin
            drive(tab[i].s, tab[i].v, tab[i].init, tab[i].clr, tab[i].e);
            got = observe();
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s[%0d]: scoreboard empty, got %s", name, i, fmt(got));
            end else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL %s[%0d]: got %s want %s", name, i, fmt(got), fmt(want));
                else begin passes++; $display("ok   %s[%0d] %s", name, i, fmt(got)); end
            end
        end
    endtask

    task automatic test_lock();
        step_t tab[$];
        logic [7:0] s_tab [5];
        logic [2:0] i_tab [5];
        s_tab = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08};
        i_tab = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
        tab.push_back(st(8'h00, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int j = 0; j < 5; j++)
            tab.push_back(st(s_tab[j], 1, 0, 0, mk(i_tab[j], 1, j == 4, 0, 0, 0, 0, 0, 0)));
        run_tab("lock", tab);
    endtask

    task automatic test_revolution();
        step_t tab[$];
        int k;
        logic [7:0] s;
        logic [15:0] rc;
        rc = 0;
        for (int j = 0; j < 12; j++) begin
            k = (4 + j) % 8;
            s = 8'd1 << k;
            if (k == 7) rc++;
            tab.push_back(st(s, 1, 0, 0, mk(3'(k), 1, 1, 0, 0, 0, 0, rc, k == 7)));
        end
        run_tab("rev", tab);
    endtask

    task automatic test_collapse();
        step_t tab[$];
        for (int j = 0; j < 3; j++)
            tab.push_back(st(8'h00, 1, 0, 0, mk(7, 0, j < 2, j == 2, 1, 0, 8'(j + 1), 2, 0)));
        tab.push_back(st(8'h00, 0, 0, 1, mk(7, 0, 0, 0, 0, 0, 0, 2, 0)));
        // clear and bad sample together: the new error survives
        tab.push_back(st(8'h00, 1, 0, 1, mk(7, 0, 0, 0, 1, 0, 1, 2, 0)));
        tab.push_back(st(8'h00, 0, 0, 1, mk(7, 0, 0, 0, 0, 0, 0, 2, 0)));
        run_tab("collapse", tab);
    endtask

    task automatic test_glitch();
        step_t tab[$];
        int k;
        tab.push_back(st(8'h00, 0, 1, 0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int j = 0; j < 9; j++) begin
            k = (j == 0) ? 7 : j - 1;
            tab.push_back(st(8'd1 << k, 1, 0, 0,
                             mk(3'(k), 1, j >= 4, 0, 0, 0, 0, (j == 8) ? 16'd1 : 16'd0, j == 8)));
        end
        tab.push_back(st(8'h01, 1, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 1, 0)));
        tab.push_back(st(8'h03, 1, 0, 0, mk(0, 0, 1, 0, 1, 0, 1, 1, 0)));
        tab.push_back(st(8'h04, 1, 0, 0, mk(2, 1, 1, 0, 1, 0, 1, 1, 0)));
        // two more misses stay below threshold only if the 0x04 hit cleared the miss count
        tab.push_back(st(8'h00, 1, 0, 0, mk(2, 0, 1, 0, 1, 0, 2, 1, 0)));
        tab.push_back(st(8'h00, 1, 0, 0, mk(2, 0, 1, 0, 1, 0, 3, 1, 0)));
        tab.push_back(st(8'h20, 1, 0, 0, mk(5, 1, 1, 0, 1, 0, 3, 1, 0)));
        run_tab("glitch", tab);
    endtask

    task automatic test_sync_restart();
        step_t tab[$];
        logic [7:0] s_tab [7];
        logic [2:0] i_tab [7];
        s_tab = '{8'h80, 8'h01, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        i_tab = '{3'd7, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        tab.push_back(st(8'h00, 0, 1, 0, mk(5, 1, 0, 0, 1, 0, 3, 0, 0)));
        tab.push_back(st(8'h00, 0, 0, 1, mk(5, 1, 0, 0, 0, 0, 0, 0, 0)));
        for (int j = 0; j < 7; j++)
            tab.push_back(st(s_tab[j], 1, 0, 0,
                             mk(i_tab[j], 1, j == 6, 0, 0, j >= 2, (j >= 2) ? 8'd1 : 8'd0, 0, 0)));
        run_tab("sync", tab);
    endtask

    task automatic test_err_sat();
        step_t tab[$];
        tab.push_back(st(8'h00, 0, 1, 0, mk(6, 1, 0, 0, 0, 1, 1, 0, 0)));
        tab.push_back(st(8'h00, 0, 0, 1, mk(6, 1, 0, 0, 0, 0, 0, 0, 0)));
        for (int j = 0; j < 260; j++)
            tab.push_back(st(8'hFF, 1, 0, 0, mk(6, 0, 0, 0, 1, 0, (j < 255) ? 8'(j + 1) : 8'd255, 0, 0)));
        tab.push_back(st(8'h00, 0, 0, 1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0)));
        run_tab("sat", tab);
    endtask

    task automatic test_timeout();
        step_t tab[$];
        logic [7:0] s_tab [5];
        logic [2:0] i_tab [5];
        s_tab = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08};
        i_tab = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
        tab.push_back(st(8'h00, 0, 1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int j = 0; j < 5; j++)
            tab.push_back(st(s_tab[j], 1, 0, 0, mk(i_tab[j], 1, j == 4, 0, 0, 0, 0, 0, 0)));
`ifdef RING_SLOT_MONITOR_TIMEOUT_EN
        for (int j = 0; j < 63; j++)
            tab.push_back(st(8'h00, 0, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0, 0)));
        tab.push_back(st(8'h00, 0, 0, 0, mk(3, 1, 0, 1, 0, 1, 0, 0, 0)));
        tab.push_back(st(8'h10, 1, 0, 0, mk(4, 1, 0, 1, 0, 1, 0, 0, 0)));
`else
        for (int j = 0; j < 100; j++)
            tab.push_back(st(8'h00, 0, 0, 0, mk(3, 1, 1, 0, 0, 0, 0, 0, 0)));
        tab.push_back(st(8'h10, 1, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 0)));
`endif
        run_tab("timeout", tab);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_revolution();
        test_collapse();
        test_glitch();
        test_sync_restart();
        test_err_sat();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ring_slot_monitor.md
Name: ring_slot_monitor

Overview:
- Sits directly downstream of the 8-bit one-hot ring counter. Each cycle it consumes the counter's rotating one-hot state.
- Checks that the state is legal one-hot and that it rotates correctly: next = {prev[W-2:0], prev[W-1]}, starting from 1000_0000.
- Encodes the active bit to a binary slot index and counts full revolutions.
- Raises sticky error/fault status so a broken rotation (e.g. the ring collapsing to 0x00) is caught in-system.

Parameters:
- WIDTH, 8, ring width in bits (>=4).
- LOCK_STEPS, 4, consecutive correct rotations required to declare lock.
- ERR_THRESH, 3, consecutive bad samples while locked that force FAULT.
- REV_W, 16, revolution counter width.
- TIMEOUT, 64, max cycles without ring_vld while locked (optional feature only).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- ring_in  in  WIDTH  ring counter state.
- ring_vld  in  1  ring_in is a new sample this cycle.
- ring_init  in  1  copy of the counter's init; forces resync.
- clr_err  in  1  clears sticky errors and FAULT.
- slot_idx  out  $clog2(WIDTH)  binary index of the set bit.
- slot_vld  out  1  slot_idx valid (sample was one-hot).
- rev_pulse  out  1  one-cycle pulse per completed revolution.
- rev_cnt  out  REV_W  revolution count; wraps.
- locked  out  1  state==LOCKED.
- fault  out  1  state==FAULT.
- err_onehot  out  1  sticky: a non-one-hot sample was seen.
- err_seq  out  1  sticky: a one-hot sample was out of sequence.
- err_cnt  out  8  total bad samples; saturates at 255.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0; internal prev, good count and miss count also 0.
- All outputs are registered and update 1 cycle after the sampling edge. Samples are taken only when ring_vld=1.
- ring_init=1 has priority over everything except reset:
  - state goes to IDLE; good, miss and rev_cnt clear; sticky errors are kept.
  - a sample presented in the same cycle is ignored.
- clr_err=1: err_onehot, err_seq and err_cnt clear. In FAULT, state goes to IDLE.
  - If a bad sample arrives in the same cycle, that sample's error wins (set dominates clear).
- Every one-hot sample drives slot_idx=index with slot_vld=1. Any other sample drives slot_vld=0 and slot_idx holds.
- IDLE:
  - one-hot sample: prev=sample, good=0, go to SYNC.
  - non-one-hot sample: set err_onehot, err_cnt+1, stay in IDLE.
- SYNC:
  - sample==rot(prev): good+1, prev=sample. When good reaches LOCK_STEPS, go to LOCKED.
  - other one-hot sample: set err_seq, err_cnt+1, good=0, prev=sample.
  - non-one-hot sample: set err_onehot, err_cnt+1, go to IDLE.
- LOCKED (flywheel):
  - The expected value is always rot(prev), and prev=expected after every sample regardless of its value.
  - Correct sample: miss=0.
  - Bad sample: set err_onehot or err_seq as applicable, err_cnt+1, miss+1. When miss reaches ERR_THRESH, go to FAULT.
- rev_pulse: fires in LOCKED only, on a correct step whose sample has bit WIDTH-1 set. rev_cnt increments in the same cycle and wraps at 2^REV_W.
- FAULT:
  - sticky; locked=0, fault=1; samples are ignored apart from slot_idx/slot_vld.
  - exit only via ring_init, clr_err or reset, always to IDLE.
- Reset or ring_init arriving mid-revolution discards any partial progress; no rev_pulse is issued.

Optional Feature:
- Macro: RING_SLOT_MONITOR_TIMEOUT_EN.
- Defined: in LOCKED, a counter counts cycles with ring_vld=0 and clears on ring_vld=1. Reaching TIMEOUT forces FAULT and sets err_seq; err_cnt is unchanged.
- Undefined: no timeout counter; ring_vld idle time is unlimited; TIMEOUT is unused.

Decomposition:
- Package ring_mon_pkg holds:
  - state enum: IDLE, SYNC, LOCKED, FAULT (2 bits);
  - defaults RING_W=8 and ERR_CNT_W=8;
  - rot() function: left rotate by 1.
- Sub-module ring_onehot_enc: purely combinational; takes WIDTH bits and outputs is_onehot and idx. Instantiated once.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ring_in=0xFF and ring_vld=1 -> all outputs 0; state IDLE.
- Lock: ring_init pulse, then samples 0x80,0x01,0x02,0x04,0x08 -> slot_idx 7,0,1,2,3; locked=1 one cycle after 0x08; err flags 0.
- Revolution: continue 0x10,0x20,0x40,0x80 -> single rev_pulse after 0x80; rev_cnt=1. A further 8 correct samples -> rev_cnt=2.
- Collapse: locked, expected 0x01, then feed 0x00 three times -> err_onehot=1, err_cnt=3, fault=1, locked=0. Then clr_err -> IDLE, err_cnt=0.
- Glitch tolerance: locked at 0x01, then 0x03 then 0x04 -> err_onehot=1, err_cnt=1, miss cleared, locked stays 1.
- Sync restart: from IDLE feed 0x80,0x01,0x04 -> err_seq=1, locked stays 0; locked=1 only after 4 further correct steps. With RING_SLOT_MONITOR_TIMEOUT_EN, 64 idle cycles while locked -> fault=1.
